// File: rtl/emc_master_seq_pkg.sv
// Shared definitions for the EMC static-memory master sequencer:
// FSM state codes, state type and small elaboration-time helpers.
package emc_master_seq_pkg;

   typedef logic [2:0] emc_state_t;

   localparam emc_state_t ST_IDLE   = 3'd0;
   localparam emc_state_t ST_WSETUP = 3'd1;
   localparam emc_state_t ST_WPULSE = 3'd2;
   localparam emc_state_t ST_WHOLD  = 3'd3;
   localparam emc_state_t ST_RWAIT  = 3'd4;
   localparam emc_state_t ST_RPULSE = 3'd5;
   localparam emc_state_t ST_RGAP   = 3'd6;
   localparam emc_state_t ST_TURN   = 3'd7;

   // Ceiling log2 with a floor of 1 so a 1-beat configuration still has a length field.
   function automatic int emc_clog2(input int val);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < 32'(val)) begin
            r = i + 1;
         end
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   // Number of byte lanes on the data bus.
   function automatic int emc_lanes(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/emc_master_seq_wait_cnt.sv
// 4-bit loadable down-counter timing one bus phase; zero marks the phase's last cycle.
module emc_master_seq_wait_cnt (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       zero
);

   logic [3:0] cnt_r;

   // Load a new phase length, otherwise count down and rest at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= 4'd0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != 4'd0) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/emc_master_seq.sv
// EMC static-memory bus master: turns valid/ready read/write commands with
// 1..MAXBEATS incrementing beats into registered CSN/OEN/WEN/BLSN/A/D timing.
module emc_master_seq
   import emc_master_seq_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int WAITOEN  = 0,
   parameter int WAITRD   = 0,
   parameter int WAITWEN  = 0,
   parameter int WAITWR   = 0,
   parameter int MAXBEATS = 4,
   parameter int LW       = emc_clog2(MAXBEATS),
   parameter int NB       = emc_lanes(DW)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [AW-1:0] cmd_adr_i,
   input  logic [LW-1:0] cmd_len_i,
   input  logic [NB-1:0] cmd_be_i,
   input  logic [DW-1:0] wdat_i,
   input  logic          wdat_valid_i,
   output logic          wdat_ready_o,
   output logic [DW-1:0] rdat_o,
   output logic          rdat_valid_o,
   output logic          done_o,
   output logic [AW-1:0] A,
   output logic [DW-1:0] D_o,
   input  logic [DW-1:0] D_i,
   output logic          D_oe,
   output logic [NB-1:0] BLSN,
   output logic          CSN,
   output logic          WEN,
   output logic          OEN
);

   // Phase lengths as counter load values (counter value N gives N+1 cycles).
   localparam logic [3:0]    WEN_LD     = 4'(WAITWEN);
   localparam logic [3:0]    WR_LD      = 4'(WAITWR);
   localparam logic [3:0]    RD_LD      = 4'(WAITRD);
   localparam logic [3:0]    OEN_LD     = 4'((WAITOEN > 0) ? (WAITOEN - 1) : 0);
   localparam bit            SKIP_RWAIT = (WAITOEN == 0);
   localparam logic [AW-1:0] ADR_STEP   = AW'(NB);
   localparam logic [LW-1:0] MAX_LEN    = LW'(MAXBEATS - 1);

   emc_state_t    state_r;
   logic [LW-1:0] beats_r;
   logic          cnt_load_s;
   logic [3:0]    cnt_val_s;
   logic          cnt_zero_s;
   logic          accept_s;
   logic          wxfer_s;
   logic          last_beat_s;
   logic [LW-1:0] len_clamp_s;

   assign accept_s    = cmd_valid_i & cmd_ready_o;
   assign wxfer_s     = wdat_valid_i & wdat_ready_o;
   assign last_beat_s = (beats_r == {LW{1'b0}});
   assign len_clamp_s = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;

   emc_master_seq_wait_cnt u_wait_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (cnt_load_s),
      .load_val (cnt_val_s),
      .zero     (cnt_zero_s)
   );

   // Select the wait-counter load for the phase being entered on this edge.
   always_comb begin
      cnt_load_s = 1'b0;
      cnt_val_s  = 4'd0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               cnt_load_s = 1'b1;
               if (cmd_we_i) begin
                  cnt_val_s = WEN_LD;
               end else if (SKIP_RWAIT) begin
                  cnt_val_s = RD_LD;
               end else begin
                  cnt_val_s = OEN_LD;
               end
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_WSETUP: begin
            if (cnt_zero_s) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = WR_LD;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_WHOLD: begin
            if (wxfer_s && !last_beat_s) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = WEN_LD;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_RWAIT: begin
            if (cnt_zero_s) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = RD_LD;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_RGAP: begin
            cnt_load_s = 1'b1;
            if (SKIP_RWAIT) begin
               cnt_val_s = RD_LD;
            end else begin
               cnt_val_s = OEN_LD;
            end
         end
         default: begin
            cnt_load_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with all bus pins, handshakes and read capture registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         beats_r      <= {LW{1'b0}};
         cmd_ready_o  <= 1'b0;
         wdat_ready_o <= 1'b0;
         rdat_o       <= {DW{1'b0}};
         rdat_valid_o <= 1'b0;
         done_o       <= 1'b0;
         A            <= {AW{1'b0}};
         D_o          <= {DW{1'b0}};
         D_oe         <= 1'b0;
         BLSN         <= {NB{1'b1}};
         CSN          <= 1'b1;
         WEN          <= 1'b1;
         OEN          <= 1'b1;
      end else begin
         rdat_valid_o <= 1'b0;
         done_o       <= 1'b0;
         wdat_ready_o <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  cmd_ready_o <= 1'b0;
                  A           <= cmd_adr_i;
                  CSN         <= 1'b0;
                  beats_r     <= len_clamp_s;
                  if (cmd_we_i) begin
                     D_o     <= wdat_i;
                     D_oe    <= 1'b1;
                     BLSN    <= ~cmd_be_i;
                     state_r <= ST_WSETUP;
                  end else begin
                     BLSN <= {NB{1'b0}};
                     if (SKIP_RWAIT) begin
                        OEN     <= 1'b0;
                        state_r <= ST_RPULSE;
                     end else begin
                        state_r <= ST_RWAIT;
                     end
                  end
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            ST_WSETUP: begin
               if (cnt_zero_s) begin
                  WEN     <= 1'b0;
                  state_r <= ST_WPULSE;
               end
            end
            ST_WPULSE: begin
               if (cnt_zero_s) begin
                  WEN          <= 1'b1;
                  wdat_ready_o <= !last_beat_s;
                  state_r      <= ST_WHOLD;
               end
            end
            ST_WHOLD: begin
               if (last_beat_s) begin
                  CSN     <= 1'b1;
                  BLSN    <= {NB{1'b1}};
                  D_oe    <= 1'b0;
                  done_o  <= 1'b1;
                  state_r <= ST_TURN;
               end else if (wxfer_s) begin
                  A       <= A + ADR_STEP;
                  D_o     <= wdat_i;
                  beats_r <= beats_r - {{(LW-1){1'b0}}, 1'b1};
                  state_r <= ST_WSETUP;
               end else begin
                  // Next beat's data not yet offered: hold the bus and keep asking.
                  wdat_ready_o <= 1'b1;
               end
            end
            ST_RWAIT: begin
               if (cnt_zero_s) begin
                  OEN     <= 1'b0;
                  state_r <= ST_RPULSE;
               end
            end
            ST_RPULSE: begin
               if (cnt_zero_s) begin
                  OEN          <= 1'b1;
                  rdat_o       <= D_i;
                  rdat_valid_o <= 1'b1;
                  if (last_beat_s) begin
                     CSN     <= 1'b1;
                     BLSN    <= {NB{1'b1}};
                     done_o  <= 1'b1;
                     state_r <= ST_TURN;
                  end else begin
                     A       <= A + ADR_STEP;
                     beats_r <= beats_r - {{(LW-1){1'b0}}, 1'b1};
                     state_r <= ST_RGAP;
                  end
               end
            end
            ST_RGAP: begin
               if (SKIP_RWAIT) begin
                  OEN     <= 1'b0;
                  state_r <= ST_RPULSE;
               end else begin
                  state_r <= ST_RWAIT;
               end
            end
            ST_TURN: begin
               cmd_ready_o <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               cmd_ready_o <= 1'b0;
               CSN         <= 1'b1;
               WEN         <= 1'b1;
               OEN         <= 1'b1;
               BLSN        <= {NB{1'b1}};
               D_oe        <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_emc_master_seq.sv
// Scoreboard bench for emc_master_seq: a behavioural slave memory on the pins,
// a reference memory updated at command issue, and a pin monitor that checks
// strobe widths, addresses, lanes, data and read returns against queued expectations.
module tb_emc_master_seq;

   localparam int AW = 8, DW = 16, NB = 2, LW = 2, MAXBEATS = 4;
   localparam int WAITOEN = 1, WAITRD = 2, WAITWEN = 0, WAITWR = 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
   logic          cmd_ready_o;
   logic [AW-1:0] cmd_adr_i = 8'h00;
   logic [LW-1:0] cmd_len_i = 2'd0;
   logic [NB-1:0] cmd_be_i = 2'b00;
   logic [DW-1:0] wdat_i = 16'h0000;
   logic          wdat_valid_i = 1'b0;
   logic          wdat_ready_o;
   logic [DW-1:0] rdat_o;
   logic          rdat_valid_o, done_o;
   logic [AW-1:0] A;
   logic [DW-1:0] D_o, D_i;
   logic          D_oe, CSN, WEN, OEN;
   logic [NB-1:0] BLSN;

   emc_master_seq #(.AW(AW), .DW(DW), .WAITOEN(WAITOEN), .WAITRD(WAITRD),
                    .WAITWEN(WAITWEN), .WAITWR(WAITWR), .MAXBEATS(MAXBEATS)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_be_i(cmd_be_i),
      .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
      .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o),
      .A(A), .D_o(D_o), .D_i(D_i), .D_oe(D_oe), .BLSN(BLSN), .CSN(CSN), .WEN(WEN), .OEN(OEN)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [1:0]  blsn;
      logic [15:0] d;
   } beat_t;

   beat_t       beat_q[$];
   logic [15:0] rd_q[$];
   int          csn_q[$];
   int          done_pend = 0;
   logic [7:0]  smem [256];
   logic [7:0]  rmem [256];
   int          tests = 0, fails = 0;
   bit          mon_en = 1'b1;

   // Slave: drives the addressed halfword while selected and output-enabled.
   logic [7:0] a_hi_s;
   assign a_hi_s = A + 8'd1;
   assign D_i = (!CSN && !OEN) ? {smem[a_hi_s], smem[A]} : 16'h0000;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Monitor state
   int    wen_len = 0, oen_len = 0, csn_len = 0, gap = 0, wgap = 0, e = 0;
   bit    rfirst = 1'b1, wfirst = 1'b1;
   logic  p_csn = 1'b1, p_wen = 1'b1, p_oen = 1'b1;
   beat_t mb;

   always @(negedge clk_i) begin
      if (rst_i || !mon_en) begin
         wen_len = 0; oen_len = 0; csn_len = 0; gap = 0; wgap = 0;
         rfirst = 1'b1; wfirst = 1'b1;
      end else begin
         if (!CSN && OEN) gap++;
         if (!CSN && WEN) wgap++;
         // Write strobe: check lanes/address/data at fall, width at rise.
         if (!WEN) begin
            wen_len++;
            if (p_wen) begin
               if (wfirst) chk("wen_setup_cycles", wgap, 1 + WAITWEN);
               wfirst = 1'b0;
               chk("wr_beat_expected", 32'(beat_q.size() > 0), 32'd1);
               if (beat_q.size() > 0) begin
                  mb = beat_q.pop_front();
                  chk("wr_beat_is_write", mb.we, 1'b1);
                  chk("wr_addr", A, mb.a);
                  chk("wr_blsn", BLSN, mb.blsn);
                  chk("wr_data", D_o, mb.d);
               end
               chk("wr_doe_csn", {D_oe, CSN}, 2'b10);
               for (int k = 0; k < 2; k++)
                  if (!BLSN[k]) smem[A + 8'(k)] = D_o[8*k +: 8];
            end
         end else if (!p_wen) begin
            chk("wen_low_cycles", wen_len, 1 + WAITWR);
            wen_len = 0;
         end
         // Read strobe
         if (!OEN) begin
            oen_len++;
            if (p_oen) begin
               chk("oen_lead_cycles", gap, rfirst ? WAITOEN : 1 + WAITOEN);
               gap = 0; rfirst = 1'b0;
               chk("rd_beat_expected", 32'(beat_q.size() > 0), 32'd1);
               if (beat_q.size() > 0) begin
                  mb = beat_q.pop_front();
                  chk("rd_beat_is_read", mb.we, 1'b0);
                  chk("rd_addr", A, mb.a);
               end
               chk("rd_blsn_doe", {BLSN, D_oe}, 3'b000);
            end
         end else if (!p_oen) begin
            chk("oen_low_cycles", oen_len, 1 + WAITRD);
            oen_len = 0;
         end
         // Chip-select window per command
         if (!CSN) csn_len++;
         else if (!p_csn) begin
            chk("csn_cmd_expected", 32'(csn_q.size() > 0), 32'd1);
            if (csn_q.size() > 0) begin
               e = csn_q.pop_front();
               if (e >= 0) chk("csn_low_cycles", csn_len, e);
            end
            csn_len = 0; gap = 0; wgap = 0; rfirst = 1'b1; wfirst = 1'b1;
         end
         if (done_o) begin
            chk("done_on_csn_rise", {CSN, p_csn}, 2'b10);
            chk("done_expected", 32'(done_pend > 0), 32'd1);
            done_pend--;
         end
         if (rdat_valid_o) begin
            chk("rvalid_after_oen", {OEN, p_oen}, 2'b10);
            chk("rdat_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) chk("rdat", rdat_o, rd_q.pop_front());
         end
      end
      p_csn = CSN; p_wen = WEN; p_oen = OEN;
   end

   task automatic wait_ready();
      int t = 0;
      do begin @(negedge clk_i); t++; end while (!cmd_ready_o && t < 200);
      chk("cmd_accept", cmd_ready_o, 1'b1);
   endtask

   // Issue one command: record expectations from the reference memory, then drive it.
   task automatic do_cmd(input logic we, input logic [7:0] adr, input logic [1:0] len,
                         input logic [1:0] be, input logic [63:0] dat, input int stall);
      int    n;
      int    t;
      logic [7:0] a;
      beat_t bt;
      n = int'(len) + 1;
      for (int b = 0; b < n; b++) begin
         a = adr + 8'(2 * b);
         bt.we = we; bt.a = a;
         if (we) begin
            bt.blsn = ~be; bt.d = dat[16*b +: 16];
            for (int k = 0; k < 2; k++)
               if (be[k]) rmem[a + 8'(k)] = bt.d[8*k +: 8];
         end else begin
            bt.blsn = 2'b00; bt.d = 16'h0000;
            rd_q.push_back({rmem[a + 8'd1], rmem[a]});
         end
         beat_q.push_back(bt);
      end
      if (!we) csn_q.push_back(n * (WAITOEN + 1 + WAITRD) + (n - 1));
      else if (n == 1) csn_q.push_back(3 + WAITWEN + WAITWR);
      else csn_q.push_back(-1);
      done_pend++;
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len;
      cmd_be_i = be; wdat_i = dat[15:0];
      wait_ready();
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0; cmd_adr_i = 8'($urandom); wdat_i = 16'($urandom);
      if (we) begin
         for (int b = 1; b < n; b++) begin
            t = 0;
            do begin @(negedge clk_i); t++; end while (!wdat_ready_o && t < 200);
            chk("wdat_ready_seen", wdat_ready_o, 1'b1);
            repeat (stall) @(negedge clk_i);
            chk("wdat_ready_held", wdat_ready_o, 1'b1);
            wdat_valid_i = 1'b1; wdat_i = dat[16*b +: 16];
            @(posedge clk_i); #1;
            wdat_valid_i = 1'b0; wdat_i = 16'($urandom);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      int bad;
      logic [7:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         smem[i] = v; rmem[i] = v;
      end
      smem[8'h20] = 8'h34; smem[8'h21] = 8'h12;
      rmem[8'h20] = 8'h34; rmem[8'h21] = 8'h12;

      // Reset state
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i); #1;
      chk("rst_pins", {CSN, WEN, OEN, BLSN, D_oe}, 6'b111110);
      chk("rst_addr_data", {A, D_o, rdat_o}, 40'h0);
      chk("rst_ready_pulses", {cmd_ready_o, done_o, rdat_valid_o, wdat_ready_o}, 4'b0000);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("ready_after_rst", cmd_ready_o, 1'b1);

      // Directed: single write, single read, stalled burst write, wrapping burst read, byte lanes
      do_cmd(1'b1, 8'h10, 2'd0, 2'b11, 64'hBEEF, 0);
      do_cmd(1'b0, 8'h20, 2'd0, 2'b11, 64'h0, 0);
      do_cmd(1'b1, 8'h30, 2'd1, 2'b11, 64'h5555_AAAA, 3);
      do_cmd(1'b0, 8'hFC, 2'd3, 2'b11, 64'h0, 0);
      do_cmd(1'b1, 8'h40, 2'd0, 2'b01, 64'h1234, 0);
      do_cmd(1'b0, 8'h40, 2'd0, 2'b11, 64'h0, 0);

      // Abort a burst write during its write pulse
      wait_ready();
      mon_en = 1'b0;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 8'h50; cmd_len_i = 2'd1;
      cmd_be_i = 2'b11; wdat_i = 16'hC0DE;
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      t = 0;
      do begin @(negedge clk_i); t++; end while (WEN && t < 50);
      chk("abort_in_wpulse", WEN, 1'b0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      chk("abort_pins", {CSN, WEN, OEN, BLSN, D_oe}, 6'b111110);
      chk("abort_no_pulse", {done_o, rdat_valid_o, cmd_ready_o}, 3'b000);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("abort_ready_back", {cmd_ready_o, done_o}, 2'b10);
      mon_en = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         do_cmd(1'($urandom), {7'($urandom), 1'b0}, 2'($urandom), 2'($urandom),
                {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end

      t = 0;
      do begin @(negedge clk_i); t++; end while (!cmd_ready_o && t < 200);
      repeat (4) @(negedge clk_i);
      chk("end_idle", cmd_ready_o, 1'b1);
      chk("beats_outstanding", beat_q.size(), 0);
      chk("reads_outstanding", rd_q.size(), 0);
      chk("done_outstanding", done_pend, 0);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (smem[i] !== rmem[i]) bad++;
      chk("slave_mem_bytes_wrong", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
